mux_n_seq: RTL and testbench

- Parametrised successor of the 2-1 mux used throughout the FFT datapath.
- Selects one of NUM_IN data lanes onto a single registered output.
- Select source is either an external select or an internal sequencer that advances every HOLD accepted samples. This auto mode provides the periodic switch pattern SDF/commutator stages need without external counters.
- Sits between butterfly/delay-line stages in the FFT pipeline.

---
 rtl/mux_n_seq.sv | 114 +++++++++++
 tb/tb_mux_n_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_seq.sv
// N-lane registered mux for the FFT datapath with an optional internal lane sequencer
// that steps through lanes every HOLD accepted samples (SDF/commutator switch pattern).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mux_n_seq #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_IN     = 2,
    parameter int HOLD       = 1,
    parameter int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    input  logic                         sel_mode,
    input  logic [SEL_W-1:0]             sel_ext,
    input  logic                         seq_clear,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        result,
    output logic [SEL_W-1:0]             sel_cur,
    output logic                         sel_err
);

    localparam int CNT_W = $clog2(HOLD + 1);

    if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
        $error("mux_n_seq: NUM_IN must be in 2..8");
    end
    if (HOLD < 1 || HOLD > 1024) begin : g_bad_hold
        $error("mux_n_seq: HOLD must be in 1..1024");
    end

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [SEL_W-1:0]      sel_cur_q, sel_cur_d;
    logic                  sel_err_q, sel_err_d;
    logic [SEL_W-1:0]      seq_sel_q, seq_sel_d;
    logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]      sel_eff;
    logic [SEL_W-1:0]      base_sel;
    logic [CNT_W-1:0]      base_cnt;
    logic [DATA_WIDTH-1:0] lane_data;
    logic                  lane_hit;

    always_comb begin
        sel_eff   = sel_mode ? (seq_clear ? '0 : seq_sel_q) : sel_ext;
        lane_data = '0;
        lane_hit  = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel_eff == SEL_W'(k)) begin
                lane_data = data_in[k*DATA_WIDTH +: DATA_WIDTH];
                lane_hit  = 1'b1;
            end
        end
    end

    // A clear restarts from (lane 0, count 0) and the same-cycle auto sample then
    // advances from there, giving hold_cnt=1 after the edge for HOLD>1.
    always_comb begin
        base_sel   = seq_clear ? '0 : seq_sel_q;
        base_cnt   = seq_clear ? '0 : hold_cnt_q;
        seq_sel_d  = base_sel;
        hold_cnt_d = base_cnt;
        if (in_valid && sel_mode) begin
            if (base_cnt == CNT_W'(HOLD - 1)) begin
                hold_cnt_d = '0;
                seq_sel_d  = (base_sel == SEL_W'(NUM_IN - 1)) ? '0 : base_sel + 1'b1;
            end else begin
                hold_cnt_d = base_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = in_valid;
        result_d    = result_q;
        sel_cur_d   = sel_cur_q;
        sel_err_d   = sel_err_q;
        if (in_valid) begin
            result_d  = lane_data;
            sel_cur_d = sel_eff;
            if (!lane_hit) begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sel_cur_q   <= '0;
            sel_err_q   <= 1'b0;
            seq_sel_q   <= '0;
            hold_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sel_cur_q   <= sel_cur_d;
            sel_err_q   <= sel_err_d;
            seq_sel_q   <= seq_sel_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sel_cur   = sel_cur_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_seq.sv
// Directed bench for mux_n_seq: a 4-lane HOLD=2 instance and a 3-lane HOLD=1 instance.
module tb_mux_n_seq;

    logic clk;
    logic rst;

    logic        a_in_valid, a_sel_mode, a_seq_clear;
    logic [31:0] a_data_in;
    logic [1:0]  a_sel_ext;
    logic        a_out_valid, a_sel_err;
    logic [7:0]  a_result;
    logic [1:0]  a_sel_cur;

    logic        b_in_valid, b_sel_mode, b_seq_clear;
    logic [23:0] b_data_in;
    logic [1:0]  b_sel_ext;
    logic        b_out_valid, b_sel_err;
    logic [7:0]  b_result;
    logic [1:0]  b_sel_cur;

    int n_cmp = 0;
    int n_err = 0;

    mux_n_seq #(.DATA_WIDTH(8), .NUM_IN(4), .HOLD(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .data_in(a_data_in),
        .sel_mode(a_sel_mode), .sel_ext(a_sel_ext), .seq_clear(a_seq_clear),
        .out_valid(a_out_valid), .result(a_result), .sel_cur(a_sel_cur), .sel_err(a_sel_err)
    );

    mux_n_seq #(.DATA_WIDTH(8), .NUM_IN(3), .HOLD(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .data_in(b_data_in),
        .sel_mode(b_sel_mode), .sel_ext(b_sel_ext), .seq_clear(b_seq_clear),
        .out_valid(b_out_valid), .result(b_result), .sel_cur(b_sel_cur), .sel_err(b_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic mode, input logic [1:0] sel, input logic clr);
        a_in_valid  = v;
        a_sel_mode  = mode;
        a_sel_ext   = sel;
        a_seq_clear = clr;
        step();
    endtask

    task automatic expect_a(input string tag, input logic v, input logic [7:0] res,
                            input logic [1:0] sel, input logic err);
        check({tag, ".valid"}, {31'b0, a_out_valid}, {31'b0, v});
        check({tag, ".result"}, {24'b0, a_result}, {24'b0, res});
        check({tag, ".sel_cur"}, {30'b0, a_sel_cur}, {30'b0, sel});
        check({tag, ".sel_err"}, {31'b0, a_sel_err}, {31'b0, err});
    endtask

    task automatic drive_b(input logic v, input logic mode, input logic [1:0] sel);
        b_in_valid  = v;
        b_sel_mode  = mode;
        b_sel_ext   = sel;
        b_seq_clear = 1'b0;
        step();
    endtask

    task automatic expect_b(input string tag, input logic v, input logic [7:0] res,
                            input logic [1:0] sel, input logic err);
        check({tag, ".valid"}, {31'b0, b_out_valid}, {31'b0, v});
        check({tag, ".result"}, {24'b0, b_result}, {24'b0, res});
        check({tag, ".sel_cur"}, {30'b0, b_sel_cur}, {30'b0, sel});
        check({tag, ".sel_err"}, {31'b0, b_sel_err}, {31'b0, err});
    endtask

    function automatic logic [7:0] lane_a(input int k);
        return 8'(8'h11 * (k + 1));
    endfunction

    initial begin
        logic [1:0] ext_sel [4];
        logic [1:0] exp_sel;
        logic [1:0] clr_exp [5];
        logic [1:0] ext2_sel [3];
        logic [1:0] resume_exp [4];
        logic [1:0] b_auto_exp [4];
        logic [7:0] b_lane [3];

        ext_sel    = '{2'd0, 2'd3, 2'd1, 2'd2};
        clr_exp    = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        ext2_sel   = '{2'd3, 2'd0, 2'd1};
        resume_exp = '{2'd2, 2'd3, 2'd3, 2'd0};
        b_auto_exp = '{2'd0, 2'd1, 2'd2, 2'd0};
        b_lane     = '{8'hA1, 8'hB2, 8'hC3};

        rst = 1'b1;
        a_data_in = 32'h44332211;
        b_data_in = 24'hC3B2A1;
        a_in_valid = 1'b0; a_sel_mode = 1'b0; a_sel_ext = '0; a_seq_clear = 1'b0;
        b_in_valid = 1'b0; b_sel_mode = 1'b0; b_sel_ext = '0; b_seq_clear = 1'b0;

        // Reset then idle: all outputs zero.
        for (int i = 0; i < 2; i++) begin
            step();
            expect_a("rst", 1'b0, 8'h00, 2'd0, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b0, 1'b0, 2'd0, 1'b0);
            expect_a("idle", 1'b0, 8'h00, 2'd0, 1'b0);
        end

        // External select, one-cycle latency.
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b0, ext_sel[i], 1'b0);
            expect_a("ext", 1'b1, lane_a(int'(ext_sel[i])), ext_sel[i], 1'b0);
        end
        drive_a(1'b0, 1'b0, 2'd0, 1'b0);
        expect_a("ext_hold", 1'b0, 8'h33, 2'd2, 1'b0);

        // Auto, HOLD=2, with gaps after samples 2, 5 and 7.
        for (int i = 0; i < 10; i++) begin
            exp_sel = 2'((i / 2) % 4);
            drive_a(1'b1, 1'b1, 2'd0, 1'b0);
            expect_a("auto", 1'b1, lane_a(int'(exp_sel)), exp_sel, 1'b0);
            if (i == 1 || i == 4 || i == 6) begin
                drive_a(1'b0, 1'b1, 2'd0, 1'b0);
                expect_a("auto_gap", 1'b0, lane_a(int'(exp_sel)), exp_sel, 1'b0);
            end
        end

        // Reset with a valid sample in flight, then restart auto from lane 0.
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 2'd0, 1'b0);
        expect_a("rst_mid", 1'b0, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;

        // seq_clear on the 5th sample forces lane 0, then 0,1,1,2 follow.
        for (int i = 0; i < 4; i++) begin
            exp_sel = 2'(i / 2);
            drive_a(1'b1, 1'b1, 2'd0, 1'b0);
            expect_a("pre_clr", 1'b1, lane_a(int'(exp_sel)), exp_sel, 1'b0);
        end
        drive_a(1'b1, 1'b1, 2'd0, 1'b1);
        expect_a("clr", 1'b1, 8'h11, 2'd0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            drive_a(1'b1, 1'b1, 2'd0, 1'b0);
            expect_a("post_clr", 1'b1, lane_a(int'(clr_exp[i])), clr_exp[i], 1'b0);
        end

        // Sequencer now at lane 2, hold_cnt 1: external samples freeze it.
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b0, ext2_sel[i], 1'b0);
            expect_a("ext_mid", 1'b1, lane_a(int'(ext2_sel[i])), ext2_sel[i], 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b1, 2'd0, 1'b0);
            expect_a("resume", 1'b1, lane_a(int'(resume_exp[i])), resume_exp[i], 1'b0);
        end

        // Final reset mid-stream: next auto sample uses lane 0.
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 2'd0, 1'b0);
        expect_a("rst_mid2", 1'b0, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        drive_a(1'b1, 1'b1, 2'd0, 1'b0);
        expect_a("after_rst", 1'b1, 8'h11, 2'd0, 1'b0);
        drive_a(1'b0, 1'b0, 2'd0, 1'b0);

        // Instance B: HOLD=1 lane changes every sample with seamless wrap.
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b1, 1'b1, 2'd0);
            expect_b("b_auto", 1'b1, b_lane[b_auto_exp[i]], b_auto_exp[i], 1'b0);
        end
        drive_b(1'b1, 1'b0, 2'd1);
        expect_b("b_ext", 1'b1, 8'hB2, 2'd1, 1'b0);
        drive_b(1'b1, 1'b0, 2'd3);
        expect_b("b_oor", 1'b1, 8'h00, 2'd3, 1'b1);
        drive_b(1'b1, 1'b0, 2'd2);
        expect_b("b_sticky", 1'b1, 8'hC3, 2'd2, 1'b1);
        drive_b(1'b0, 1'b0, 2'd0);
        expect_b("b_sticky_idle", 1'b0, 8'hC3, 2'd2, 1'b1);
        rst = 1'b1;
        drive_b(1'b0, 1'b0, 2'd0);
        expect_b("b_rst", 1'b0, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
